// File: rtl/hack_seq_if.sv
// Hack sequencer bus: instruction port, data port and ALU operand/result lines.
// master = sequencer side, slave = memories plus the combinational ALU.
interface hack_seq_if;
    logic        imem_req;
    logic [14:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;

    logic        dmem_rd_req;
    logic        dmem_wr_req;
    logic [14:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        dmem_ack;
    logic [15:0] dmem_rdata;

    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic        zx;
    logic        nx;
    logic        zy;
    logic        ny;
    logic        f;
    logic        no;
    logic [15:0] alu_out;
    logic        alu_zr;
    logic        alu_ng;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_data,
        output dmem_rd_req, dmem_wr_req, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata,
        output alu_x, alu_y, zx, nx, zy, ny, f, no,
        input  alu_out, alu_zr, alu_ng
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_data,
        input  dmem_rd_req, dmem_wr_req, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata,
        input  alu_x, alu_y, zx, nx, zy, ny, f, no,
        output alu_out, alu_zr, alu_ng
    );
endinterface

// File: rtl/hack_seq.sv
// Multi-cycle Hack CPU sequencer: FETCH, DECODE, optional MREAD, EXEC, optional MWRITE.
// Latency 2 cycles per A-instruction, 3+ per C-instruction; every request holds until acked.
module hack_seq #(
    parameter logic [14:0] RESET_PC = 15'd0
) (
    input  logic       clock,
    input  logic       reset_n,
    hack_seq_if.master bus
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        MREAD  = 3'd2,
        EXEC   = 3'd3,
        MWRITE = 3'd4
    } state_t;

    state_t      state;
    logic [15:0] a_reg;
    logic [15:0] d_reg;
    logic [15:0] ir;
    logic [15:0] m_lat;
    logic [14:0] pc;
    logic [14:0] daddr_q;
    logic [15:0] wdata_q;
    logic        jump;

    assign jump = (ir[2] & bus.alu_ng)
                | (ir[1] & bus.alu_zr)
                | (ir[0] & ~bus.alu_zr & ~bus.alu_ng);

    // FETCH is also the reset state, so the fetch request is masked while reset is held.
    assign bus.imem_req    = reset_n & (state == FETCH);
    assign bus.imem_addr   = pc;
    assign bus.dmem_rd_req = (state == MREAD);
    assign bus.dmem_wr_req = (state == MWRITE);
    assign bus.dmem_addr   = daddr_q;
    assign bus.dmem_wdata  = wdata_q;

    assign bus.alu_x = d_reg;
    assign bus.alu_y = ir[12] ? m_lat : a_reg;
    assign {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = ir[11:6];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= FETCH;
            a_reg   <= 16'd0;
            d_reg   <= 16'd0;
            ir      <= 16'd0;
            m_lat   <= 16'd0;
            pc      <= RESET_PC;
            daddr_q <= 15'd0;
            wdata_q <= 16'd0;
        end else begin
            case (state)
                FETCH: begin
                    if (bus.imem_ack) begin
                        ir    <= bus.imem_data;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    if (!ir[15]) begin
                        a_reg <= {1'b0, ir[14:0]};
                        pc    <= pc + 15'd1;
                        state <= FETCH;
                    end else if (ir[12]) begin
                        daddr_q <= a_reg[14:0];
                        state   <= MREAD;
                    end else begin
                        state <= EXEC;
                    end
                end
                MREAD: begin
                    if (bus.dmem_ack) begin
                        m_lat <= bus.dmem_rdata;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    // Jump target and write address use A as it was before this cycle's update.
                    if (ir[5]) begin
                        a_reg <= bus.alu_out;
                    end
                    if (ir[4]) begin
                        d_reg <= bus.alu_out;
                    end
                    pc <= jump ? a_reg[14:0] : pc + 15'd1;
                    if (ir[3]) begin
                        daddr_q <= a_reg[14:0];
                        wdata_q <= bus.alu_out;
                        state   <= MWRITE;
                    end else begin
                        state <= FETCH;
                    end
                end
                MWRITE: begin
                    if (bus.dmem_ack) begin
                        state <= FETCH;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hack_seq.sv
// Bench for hack_seq: memories and ALU around the DUT, checked against an instruction-level Hack model.
module tb_hack_seq;

    localparam logic [14:0] RST_PC = 15'd0;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    hack_seq_if bus ();

    hack_seq #(.RESET_PC(RST_PC)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    logic [15:0] imem [0:32767];
    logic [15:0] dmem [0:32767];
    logic [15:0] mmem [0:32767];

    int tests = 0;
    int fails = 0;
    int fetches = 0;

    logic [15:0] m_a, m_d;
    int          m_pc;

    logic        exp_rd, exp_wr;
    int          exp_rd_addr, exp_wr_addr;
    logic [15:0] exp_wr_data, exp_x, exp_y;
    logic [5:0]  exp_ctrl;

    int exec_in, iw, rw, ww, hold;
    int imin, imax, dmin, dmax;
    bit noise;

    logic        p_i, p_r, p_w;
    logic [14:0] p_iaddr, p_daddr;
    logic [15:0] p_wdata;

    int          flog[$], rlog[$], wlog_a[$], whold[$];
    logic [15:0] wlog_d[$], xlog[$], ylog[$];
    logic [5:0]  clog[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                             input logic [5:0] c);
        logic [15:0] xx, yy, o;
        xx = c[5] ? 16'h0000 : x;
        if (c[4]) xx = ~xx;
        yy = c[3] ? 16'h0000 : y;
        if (c[2]) yy = ~yy;
        o = c[1] ? xx + yy : xx & yy;
        if (c[0]) o = ~o;
        return o;
    endfunction

    // Instruction-level effect of one Hack instruction on A, D, PC and memory.
    task automatic model_step(input logic [15:0] ins);
        logic [15:0] y, o;
        logic        lt, eq, gt, take;
        int          a_old;
        if (!ins[15]) begin
            m_a  = {1'b0, ins[14:0]};
            m_pc = (m_pc + 1) % 32768;
        end else begin
            a_old    = int'(m_a) % 32768;
            y        = ins[12] ? mmem[a_old] : m_a;
            exp_ctrl = ins[11:6];
            exp_x    = m_d;
            exp_y    = y;
            if (ins[12]) begin
                exp_rd      = 1'b1;
                exp_rd_addr = a_old;
            end else begin
                exec_in = 2;
            end
            o    = hack_alu(m_d, y, ins[11:6]);
            lt   = $signed(o) < 0;
            eq   = (o == 16'd0);
            gt   = !lt && !eq;
            take = (ins[2] && lt) || (ins[1] && eq) || (ins[0] && gt);
            m_pc = take ? a_old : (m_pc + 1) % 32768;
            if (ins[3]) begin
                exp_wr      = 1'b1;
                exp_wr_addr = a_old;
                exp_wr_data = o;
                mmem[a_old] = o;
            end
            if (ins[5]) m_a = o;
            if (ins[4]) m_d = o;
        end
    endtask

    task automatic tick();
        logic [15:0] o;
        @(negedge clock);
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        o = hack_alu(bus.alu_x, bus.alu_y, {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no});
        bus.alu_out = o;
        bus.alu_zr  = (o == 16'd0);
        bus.alu_ng  = o[15];

        check_eq("req_excl", 32'($countones({bus.imem_req, bus.dmem_rd_req, bus.dmem_wr_req}) <= 1), 1);
        if (p_i) check_eq("imem_hold", {bus.imem_req, bus.imem_addr}, {1'b1, p_iaddr});
        if (p_r) check_eq("rd_hold", {bus.dmem_rd_req, bus.dmem_addr}, {1'b1, p_daddr});
        if (p_w) check_eq("wr_hold", {bus.dmem_wr_req, bus.dmem_addr, bus.dmem_wdata}, {1'b1, p_daddr, p_wdata});

        if (exec_in > 0) begin
            exec_in--;
            if (exec_in == 0) begin
                check_eq("exec_ctrl", {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no}, exp_ctrl);
                check_eq("exec_alu_x", bus.alu_x, exp_x);
                check_eq("exec_alu_y", bus.alu_y, exp_y);
                clog.push_back({bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no});
                xlog.push_back(bus.alu_x);
                ylog.push_back(bus.alu_y);
            end
        end

        if (bus.imem_req) begin
            if (iw < 0) begin
                iw = $urandom_range(imax, imin);
                check_eq("rd_before_fetch", exp_rd, 0);
                check_eq("wr_before_fetch", exp_wr, 0);
            end
            if (iw == 0) begin
                bus.imem_ack  = 1'b1;
                bus.imem_data = imem[bus.imem_addr];
                flog.push_back(int'(bus.imem_addr));
                check_eq("fetch_addr", bus.imem_addr, m_pc);
                model_step(imem[m_pc]);
                fetches++;
                iw = -1;
            end else begin
                iw--;
            end
        end

        if (bus.dmem_rd_req) begin
            if (rw < 0) begin
                rw = $urandom_range(dmax, dmin);
                check_eq("rd_expected", exp_rd, 1);
                check_eq("rd_addr", bus.dmem_addr, exp_rd_addr);
                rlog.push_back(int'(bus.dmem_addr));
            end
            if (rw == 0) begin
                bus.dmem_ack   = 1'b1;
                bus.dmem_rdata = dmem[bus.dmem_addr];
                exp_rd  = 1'b0;
                exec_in = 1;
                rw = -1;
            end else begin
                rw--;
            end
        end

        if (bus.dmem_wr_req) begin
            if (ww < 0) begin
                ww = $urandom_range(dmax, dmin);
                hold = 0;
                check_eq("wr_expected", exp_wr, 1);
                check_eq("wr_addr", bus.dmem_addr, exp_wr_addr);
                check_eq("wr_data", bus.dmem_wdata, exp_wr_data);
            end
            hold++;
            if (ww == 0) begin
                bus.dmem_ack = 1'b1;
                dmem[bus.dmem_addr] = bus.dmem_wdata;
                wlog_a.push_back(int'(bus.dmem_addr));
                wlog_d.push_back(bus.dmem_wdata);
                whold.push_back(hold);
                exp_wr = 1'b0;
                ww = -1;
            end else begin
                ww--;
            end
        end

        // Acks with no request outstanding must be ignored by the sequencer.
        if (noise) begin
            if (!bus.imem_req && $urandom_range(3, 0) == 0) begin
                bus.imem_ack  = 1'b1;
                bus.imem_data = 16'($urandom);
            end
            if (!bus.dmem_rd_req && !bus.dmem_wr_req && $urandom_range(3, 0) == 0) begin
                bus.dmem_ack   = 1'b1;
                bus.dmem_rdata = 16'($urandom);
            end
        end

        p_i     = bus.imem_req && !bus.imem_ack;
        p_r     = bus.dmem_rd_req && !bus.dmem_ack;
        p_w     = bus.dmem_wr_req && !bus.dmem_ack;
        p_iaddr = bus.imem_addr;
        p_daddr = bus.dmem_addr;
        p_wdata = bus.dmem_wdata;
    endtask

    task automatic run_fetches(input int n);
        int target, budget;
        target = fetches + n;
        budget = n * 30 + 50;
        while (fetches < target && budget > 0) begin
            tick();
            budget--;
        end
        check_eq("run_progress", fetches, target);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32768; i++) begin
            imem[i] = 16'd0;
            dmem[i] = 16'd0;
            mmem[i] = 16'd0;
        end
    endtask

    task automatic apply_reset();
        reset_n      = 1'b0;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_eq("rst_reqs", {bus.imem_req, bus.dmem_rd_req, bus.dmem_wr_req}, 0);
        check_eq("rst_daddr", bus.dmem_addr, 0);
        check_eq("rst_wdata", bus.dmem_wdata, 0);
        check_eq("rst_alu_x", bus.alu_x, 0);
        check_eq("rst_alu_y", bus.alu_y, 0);
        m_a = 16'd0; m_d = 16'd0; m_pc = int'(RST_PC);
        exp_rd = 1'b0; exp_wr = 1'b0; exec_in = 0;
        iw = -1; rw = -1; ww = -1; hold = 0;
        p_i = 1'b0; p_r = 1'b0; p_w = 1'b0;
        flog.delete(); rlog.delete(); wlog_a.delete(); wlog_d.delete();
        whold.delete(); xlog.delete(); ylog.delete(); clog.delete();
        for (int i = 0; i < 32768; i++) mmem[i] = dmem[i];
        @(posedge clock);
        #2 reset_n = 1'b1;
        #1 check_eq("rst_fetch", {bus.imem_req, bus.imem_addr}, {1'b1, RST_PC});
    endtask

    initial begin
        bus.imem_ack = 1'b0; bus.imem_data = 16'd0;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = 16'd0;
        bus.alu_out = 16'd0; bus.alu_zr = 1'b0; bus.alu_ng = 1'b0;
        imin = 0; imax = 0; dmin = 0; dmax = 0; noise = 1'b0;

        // @5 then D=A with zero-wait fetches.
        clear_mem();
        imem[0] = 16'h0005; imem[1] = 16'hEC10;
        apply_reset();
        run_fetches(3);
        check_eq("t1_fetch1", flog[1], 1);
        check_eq("t1_fetch2", flog[2], 2);
        check_eq("t1_a_is_5", ylog[0], 5);
        check_eq("t1_no_dmem", rlog.size() + wlog_a.size(), 0);

        // @7, D=A, M=D.
        clear_mem();
        imem[0] = 16'h0007; imem[1] = 16'hEC10; imem[2] = 16'hE308;
        apply_reset();
        run_fetches(4);
        check_eq("t2_ctrl", clog[0], 6'b110000);
        check_eq("t2_alu_y", ylog[0], 7);
        check_eq("t2_fetch2", flog[2], 2);
        check_eq("t2_no_read", rlog.size(), 0);
        check_eq("t2_d_addr", wlog_a[0], 7);
        check_eq("t2_d_data", wlog_d[0], 7);

        // M=D+1 with a 3-cycle delayed write ack.
        clear_mem();
        imem[0] = 16'h0007; imem[1] = 16'hEC10; imem[2] = 16'h0064; imem[3] = 16'hE7C8;
        dmin = 3; dmax = 3;
        apply_reset();
        run_fetches(5);
        check_eq("t3_hold", whold[0], 4);
        check_eq("t3_waddr", wlog_a[0], 100);
        check_eq("t3_wdata", wlog_d[0], 8);
        check_eq("t3_next_pc", flog[4], 4);
        dmin = 0; dmax = 0;

        // D;JEQ taken and not taken, then a PC wrap at 0x7FFF.
        clear_mem();
        imem[0]  = 16'h0014; imem[1]  = 16'hE302;
        imem[20] = 16'h0005; imem[21] = 16'hEC10; imem[22] = 16'h0014; imem[23] = 16'hE302;
        imem[24] = 16'h7FFF; imem[25] = 16'hEA87; imem[32767] = 16'hEC10;
        apply_reset();
        run_fetches(10);
        begin
            int exp4 [10] = '{0, 1, 20, 21, 22, 23, 24, 25, 32767, 0};
            check_eq("t4_nfetch", flog.size(), 10);
            for (int i = 0; i < 10 && i < flog.size(); i++) check_eq("t4_fetch", flog[i], exp4[i]);
        end

        // AM=M+1: the write targets the old A.
        clear_mem();
        imem[0] = 16'h0064; imem[1] = 16'hFDE8; imem[2] = 16'hEC10;
        dmem[100] = 16'd41;
        apply_reset();
        run_fetches(4);
        check_eq("t5_raddr", rlog[0], 100);
        check_eq("t5_m_in", ylog[0], 41);
        check_eq("t5_waddr", wlog_a[0], 100);
        check_eq("t5_wdata", wlog_d[0], 42);
        check_eq("t5_new_a", ylog[1], 42);

        // Asynchronous reset in the middle of an unacknowledged write.
        clear_mem();
        imem[0] = 16'h0064; imem[1] = 16'hEC10; imem[2] = 16'hE7C8;
        dmin = 10; dmax = 10;
        apply_reset();
        for (int k = 0; k < 60 && !bus.dmem_wr_req; k++) tick();
        check_eq("t6_in_write", bus.dmem_wr_req, 1);
        tick();
        tick();
        #1 reset_n = 1'b0;
        #1;
        check_eq("t6_async_wr", bus.dmem_wr_req, 0);
        check_eq("t6_async_daddr", bus.dmem_addr, 0);
        dmin = 0; dmax = 0;
        imem[0] = 16'hEC10;
        apply_reset();
        run_fetches(2);
        check_eq("t6_fetch0", flog[0], RST_PC);
        check_eq("t6_d_cleared", xlog[0], 0);
        check_eq("t6_a_cleared", ylog[0], 0);

        // Random programs, random ack delays, spurious acks.
        for (int i = 0; i < 32768; i++) begin
            imem[i] = ($urandom_range(9, 0) < 4) ? {1'b0, 15'($urandom)} : {1'b1, 15'($urandom)};
            dmem[i] = 16'($urandom);
        end
        imin = 0; imax = 2; dmin = 0; dmax = 3; noise = 1'b1;
        apply_reset();
        run_fetches(1000);
        apply_reset();
        run_fetches(300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/hack_seq.md
Name: hack_seq

Overview:
- Multi-cycle Hack CPU sequencer. It is the initiator side of the ALU interface: it owns the A, D and PC registers and the instruction register.
- It fetches instructions over a request/acknowledge instruction port and decodes them into zx/nx/zy/ny/f/no. It drives the ALU operands and consumes the ALU result, zr and ng.
- It performs data-memory reads and writes over a request/acknowledge data port.
- It sits between the instruction/data memories and the combinational ALU in the CPU top.

Parameters:
- RESET_PC, 0, PC value loaded on reset (15-bit).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  15  fetch address; equals PC.
- imem_ack  in  1  fetch complete; imem_data valid this cycle.
- imem_data  in  16  instruction word.
- dmem_rd_req  out  1  data read request.
- dmem_wr_req  out  1  data write request.
- dmem_addr  out  15  data address.
- dmem_wdata  out  16  write data.
- dmem_ack  in  1  data transfer complete; dmem_rdata valid on reads.
- dmem_rdata  in  16  read data (M).
- alu_x  out  16  D register.
- alu_y  out  16  A when ir[12]=0, latched M when ir[12]=1.
- zx, nx, zy, ny, f, no  out  1 each  ALU controls, ir[11:6] in that order.
- alu_out  in  16  ALU result.
- alu_zr  in  1  ALU zero flag.
- alu_ng  in  1  ALU negative flag.

Behaviour:
- Reset is asynchronous and active-low on reset_n. On reset:
  - A=D=IR=M latch=0, PC=RESET_PC, state=FETCH.
  - All req outputs are 0 immediately, and dmem_addr=0, dmem_wdata=0.
  - A transaction in flight is abandoned with no retry.
- States are FETCH, DECODE, MREAD, EXEC, MWRITE.
- FETCH:
  - imem_req=1, imem_addr=PC.
  - On the cycle imem_ack=1: IR<=imem_data, go to DECODE.
  - A same-cycle ack is legal, giving zero-wait fetch.
- DECODE, A-instruction (ir[15]=0):
  - A<={1'b0,ir[14:0]}, PC<=PC+1, go to FETCH.
  - Minimum 2 cycles per A-instruction.
- DECODE, C-instruction (ir[15]=1):
  - If ir[12]=1 go to MREAD, else go to EXEC.
  - ir[14:13] are ignored.
- MREAD:
  - dmem_rd_req=1, dmem_addr=A[14:0].
  - On dmem_ack: Mlatch<=dmem_rdata, go to EXEC.
- EXEC (single cycle; the ALU is combinational and is sampled only here):
  - dest d1=ir[5] writes A<=alu_out. d2=ir[4] writes D<=alu_out. d3=ir[3] requests an M write.
  - jump = (ir[2]&alu_ng) | (ir[1]&alu_zr) | (ir[0]&~alu_zr&~alu_ng).
  - PC<=jump ? A_old[14:0] : PC+1, where A_old is A before this cycle's write.
  - If d3: waddr<=A_old[14:0], wdata<=alu_out, go to MWRITE. Otherwise go to FETCH.
- MWRITE:
  - dmem_wr_req=1, dmem_addr=waddr, dmem_wdata=wdata.
  - On dmem_ack go to FETCH.
  - When d1 and d3 are both set, the write still targets the old A.
- Handshake rules:
  - A req stays high, with addr/data stable, until the cycle ack is sampled high, then drops the next cycle.
  - Ack while no req is outstanding is ignored.
  - dmem_rd_req and dmem_wr_req are never high together.
  - imem_req is never high together with either dmem request.
- Arithmetic:
  - PC is 15-bit and wraps: 0x7FFF+1 = 0x0000.
  - A is 16-bit, but only A[14:0] is used as an address or jump target.
- Output validity:
  - ALU controls and alu_x/alu_y are driven continuously from IR/D/A/Mlatch.
  - They are valid for sampling only in EXEC.
- Unconditional jump (jump bits 111) is taken regardless of flags. Null jump (000) is never taken.

Test Plan:
1. Reset, then release; imem_ack=1 with 0x0005 -> imem_req=1 and imem_addr=0 in the first cycle; after DECODE, A=5, and the next fetch has imem_addr=1; no dmem request.
2. @7 followed by 0xEC10 (D=A) -> ALU controls = 110000 in EXEC, alu_y=7; D=7; next imem_addr=2; dmem_rd_req and dmem_wr_req stay 0.
3. A=100, D=7, then 0xE7C8 (M=D+1), with dmem_ack delayed 3 cycles -> dmem_wr_req held 4 cycles with dmem_addr=100 and dmem_wdata=8 stable; then FETCH at PC+1.
4. @20 followed by 0xE302 (D;JEQ) -> with D=0 the next imem_addr=20; with D=5 the next imem_addr = PC+1. Also: PC=0x7FFF executing a non-jump -> next imem_addr=0.
5. A=100, memory[100]=41, then 0xFDE8 (AM=M+1) -> dmem_rd_req with dmem_addr=100, alu_y=41; A=42; then dmem_wr_req with dmem_addr=100 (old A) and dmem_wdata=42.
6. reset_n low mid-MWRITE (before ack) -> dmem_wr_req=0 the same cycle with no clock edge needed; A=D=0, PC=RESET_PC; after release, FETCH with imem_addr=RESET_PC.
